// File: rtl/sigma_delta_dac_if.sv
// Sample-side handshake and PDM output bundle for sigma_delta_dac.
// master drives PCM samples; slave is the DAC.
interface sigma_delta_dac_if #(
  parameter int DAC_BITLEN = 16
);
  logic [DAC_BITLEN-1:0] dac_input;
  logic                  dac_input_valid;
  logic                  dac_input_ready;
  logic                  dac_output;
  logic                  dac_underflow;

  modport master (
    output dac_input, dac_input_valid,
    input  dac_input_ready, dac_output, dac_underflow
  );

  modport slave (
    input  dac_input, dac_input_valid,
    output dac_input_ready, dac_output, dac_underflow
  );
endinterface

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta DAC: one-entry sample buffer, CIC interpolator, 1-bit modulator.
// Optional TPDF-style LFSR dither on the modulator input when SIGMA_DELTA_DAC_DITHER_EN is defined.
module sigma_delta_dac #(
  parameter int OVERSAMPLE_RATE = 256,
  parameter int CIC_STAGES      = 2,
  parameter int DAC_BITLEN      = 16,
  parameter bit SIGNED_INPUT    = 1'b1
) (
  input logic              clk,
  input logic              rst,
  sigma_delta_dac_if.slave bus
);
  localparam int OSR_W = $clog2(OVERSAMPLE_RATE);
  localparam int CIC_W = DAC_BITLEN + CIC_STAGES * OSR_W;
  localparam int SHIFT = (CIC_STAGES - 1) * OSR_W;
  localparam int B     = DAC_BITLEN;

  localparam logic signed [CIC_W-1:0] SAT_HI = {{(CIC_W-B+1){1'b0}}, {(B-1){1'b1}}};
  localparam logic signed [CIC_W-1:0] SAT_LO = {{(CIC_W-B+1){1'b1}}, {(B-1){1'b0}}};

  logic [OSR_W-1:0] osr_cnt;
  logic             strobe;
  logic             full;
  logic [B-1:0]     hold_q;
  logic [B-1:0]     last_q;
  logic             uf_q;
  logic             out_q;
  logic             accept;

  assign strobe = &osr_cnt;
  assign accept = bus.dac_input_valid && !full;

  assign bus.dac_input_ready = !full;
  assign bus.dac_underflow   = uf_q;
  assign bus.dac_output      = out_q;

  // Accept and a full-consume are mutually exclusive because accept needs !full.
  always_ff @(posedge clk) begin
    if (rst) begin
      osr_cnt <= '0;
      full    <= 1'b0;
      hold_q  <= '0;
      last_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      osr_cnt <= osr_cnt + 1'b1;
      uf_q    <= strobe && !full;
      if (strobe && full) begin
        last_q <= hold_q;
        full   <= 1'b0;
      end else if (accept) begin
        hold_q <= bus.dac_input;
        full   <= 1'b1;
      end
    end
  end

  logic [B-1:0]             sample_raw;
  logic [B-1:0]             sample_s;
  logic signed [CIC_W-1:0]  sample_ext;
  logic signed [CIC_W-1:0]  comb_out;
  logic signed [CIC_W-1:0]  stuff_q;
  logic signed [CIC_W-1:0]  integ_out;

  assign sample_raw = full ? hold_q : last_q;
  assign sample_s   = SIGNED_INPUT ? sample_raw : {~sample_raw[B-1], sample_raw[B-2:0]};
  assign sample_ext = {{(CIC_W-B){sample_s[B-1]}}, sample_s};

  for (genvar k = 0; k < CIC_STAGES; k++) begin : g_comb
    logic signed [CIC_W-1:0] c_in;
    logic signed [CIC_W-1:0] c_out;
    logic signed [CIC_W-1:0] c_dly;
    if (k == 0) begin : g_first
      assign c_in = sample_ext;
    end else begin : g_next
      assign c_in = g_comb[k-1].c_out;
    end
    assign c_out = c_in - c_dly;
    always_ff @(posedge clk) begin
      if (rst)         c_dly <= '0;
      else if (strobe) c_dly <= c_in;
    end
  end

  assign comb_out = g_comb[CIC_STAGES-1].c_out;

  // Zero-stuffing: the comb result is presented to the integrators for one cycle per frame.
  always_ff @(posedge clk) begin
    if (rst) stuff_q <= '0;
    else     stuff_q <= strobe ? comb_out : '0;
  end

  for (genvar k = 0; k < CIC_STAGES; k++) begin : g_int
    logic signed [CIC_W-1:0] i_in;
    logic signed [CIC_W-1:0] i_acc;
    if (k == 0) begin : g_first
      assign i_in = stuff_q;
    end else begin : g_next
      assign i_in = g_int[k-1].i_acc;
    end
    always_ff @(posedge clk) begin
      if (rst) i_acc <= '0;
      else     i_acc <= i_acc + i_in;
    end
  end

  assign integ_out = g_int[CIC_STAGES-1].i_acc;

  logic signed [CIC_W-1:0] shifted;
  logic [B-1:0]            x;
  logic [B-1:0]            u;
  logic [B-1:0]            u_mod;

  assign shifted = integ_out >>> SHIFT;

  always_comb begin
    x = shifted[B-1:0];
    if (shifted > SAT_HI)      x = {1'b0, {(B-1){1'b1}}};
    else if (shifted < SAT_LO) x = {1'b1, {(B-1){1'b0}}};
  end

  assign u = {~x[B-1], x[B-2:0]};

`ifdef SIGMA_DELTA_DAC_DITHER_EN
  logic [15:0]      lfsr_q;
  logic signed [B+1:0] u_dith;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // d = lfsr[0] - lfsr[1]; clamp keeps the accumulator input inside the unsigned range.
  always_comb begin
    u_dith = {2'b00, u};
    if (lfsr_q[0] && !lfsr_q[1])      u_dith = u_dith + (B+2)'(1);
    else if (!lfsr_q[0] && lfsr_q[1]) u_dith = u_dith - (B+2)'(1);
    if (u_dith[B+1])  u_mod = '0;
    else if (u_dith[B]) u_mod = '1;
    else              u_mod = u_dith[B-1:0];
  end
`else
  assign u_mod = u;
`endif

  logic [B-1:0] acc_q;
  logic [B:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, u_mod};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      out_q <= 1'b0;
    end else begin
      acc_q <= sum[B-1:0];
      out_q <= sum[B];
    end
  end
endmodule

// File: tb/tb_sigma_delta_dac.sv
// Scoreboard bench for sigma_delta_dac: signed and offset-binary instances driven in lockstep,
// ones-density compared against an arithmetic model of the transfer function.
module tb_sigma_delta_dac;
  localparam int OSR = 256;
  localparam int B   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sigma_delta_dac_if #(.DAC_BITLEN(B)) bus_s ();
  sigma_delta_dac_if #(.DAC_BITLEN(B)) bus_u ();

  sigma_delta_dac #(.OVERSAMPLE_RATE(OSR), .CIC_STAGES(2), .DAC_BITLEN(B), .SIGNED_INPUT(1'b1))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));
  sigma_delta_dac #(.OVERSAMPLE_RATE(OSR), .CIC_STAGES(2), .DAC_BITLEN(B), .SIGNED_INPUT(1'b0))
    dut_u (.clk(clk), .rst(rst), .bus(bus_u.slave));

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int          exp_s;
    int          exp_u;
    logic [15:0] v;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_busy = 1'b0;
  int   sb_uf    = 0;

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference: steady-state ones per frame = OSR * u / 2^B, u being the offset-binary level.
  function automatic int level_signed(input logic [15:0] v);
    return int'($signed(v)) + 32768;
  endfunction

  function automatic int level_unsigned(input logic [15:0] v);
    return int'(v);
  endfunction

  function automatic int ones_per_frame(input int u);
    return (u * OSR + 32768) / 65536;
  endfunction

  function automatic bit near(input int a, input int b, input int tol);
    return ((a > b) ? (a - b) : (b - a)) <= tol;
  endfunction

  task automatic drive(input logic valid, input logic [15:0] d);
    bus_s.dac_input_valid = valid;
    bus_s.dac_input       = d;
    bus_u.dac_input_valid = valid;
    bus_u.dac_input       = d;
  endtask

  task automatic count_ones(input int n, output int cs, output int cu);
    cs = 0;
    cu = 0;
    repeat (n) begin
      @(negedge clk);
      cs += int'(bus_s.dac_output);
      cu += int'(bus_u.dac_output);
    end
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 16'h0000);
    repeat (n) @(negedge clk);
    check("reset_state_s", {bus_s.dac_input_ready, bus_s.dac_underflow, bus_s.dac_output} == 3'b100,
          int'({bus_s.dac_input_ready, bus_s.dac_underflow, bus_s.dac_output}), 4);
    check("reset_state_u", {bus_u.dac_input_ready, bus_u.dac_underflow, bus_u.dac_output} == 3'b100,
          int'({bus_u.dac_input_ready, bus_u.dac_underflow, bus_u.dac_output}), 4);
    rst = 1'b0;
  endtask

  // Called on the negedge where rst was released; k counts clock edges after release.
  task automatic idle_check(input int n);
    int alt_err = 0;
    int uf_err  = 0;
    int ones    = 0;
    int aper    = 0;
    logic o, p1, p2;
    p1 = 1'b0;
    p2 = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      o = bus_s.dac_output;
      if (bus_s.dac_underflow != ((k % OSR) == 0)) uf_err++;
      if (o != ((k % 2) == 0)) alt_err++;
      if (k > 2 && o != p2) aper++;
      ones += int'(o);
      p2 = p1;
      p1 = o;
    end
    check("idle_underflow_timing", uf_err == 0, uf_err, 0);
`ifdef SIGMA_DELTA_DAC_DITHER_EN
    check("dither_ones", near(ones, n / 2, 8), ones, n / 2);
    check("dither_not_2_periodic", aper > 0, aper, 1);
`else
    check("idle_alternation", alt_err == 0, alt_err, 0);
`endif
  endtask

  task automatic wait_uf();
    int i = 0;
    while (!bus_s.dac_underflow && i < 2 * OSR) begin
      @(negedge clk);
      i++;
    end
    check("underflow_seen", bus_s.dac_underflow == 1'b1, int'(bus_s.dac_underflow), 1);
  endtask

  task automatic run_segment(input logic [15:0] v);
    int   acc_n = 0;
    int   c = 0;
    int   last_c = 0;
    int   sp_err = 0;
    logic hs;
    exp_t e;
    drive(1'b1, v);
    while (acc_n < 6 && c < 6 * OSR + 512) begin
      hs = bus_s.dac_input_ready && bus_s.dac_input_valid;
      @(posedge clk);
      c++;
      if (hs) begin
        if (acc_n == 0) begin
          e.v     = v;
          e.exp_s = ones_per_frame(level_signed(v));
          e.exp_u = ones_per_frame(level_unsigned(v));
          exp_q.push_back(e);
        end else if (c - last_c != OSR) begin
          sp_err++;
        end
        last_c = c;
        acc_n++;
      end
      @(negedge clk);
      if (bus_s.dac_underflow) sb_uf++;
    end
    check("segment_accepts", acc_n == 6, acc_n, 6);
    check("accept_spacing", sp_err == 0, sp_err, 0);
  endtask

  // Monitor: once a new level is accepted, wait for settling and compare one frame's density.
  initial begin
    exp_t e;
    int   cs, cu;
    forever begin
      while (exp_q.size() == 0) @(posedge clk);
      e = exp_q.pop_front();
      mon_busy = 1'b1;
      repeat (4 * OSR) @(posedge clk);
      count_ones(OSR, cs, cu);
      check($sformatf("sb_signed_%04h", e.v), near(cs, e.exp_s, 1), cs, e.exp_s);
      check($sformatf("sb_offset_%04h", e.v), near(cu, e.exp_u, 1), cu, e.exp_u);
      mon_busy = 1'b0;
    end
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vals[$];
    logic [15:0] v, w;
    int cs, cu, i;

    drive(1'b0, 16'h0000);

    // Power-up reset, then idle with no samples.
    apply_reset(3);
    idle_check(4096);

    // Continuous feed: boundary levels then random ones.
    vals = '{16'h4000, 16'h7FFF, 16'h8000, 16'h0000};
    repeat (3) vals.push_back(16'($urandom_range(0, 65535)));
    foreach (vals[j]) run_segment(vals[j]);
    check("segments_no_underflow", sb_uf == 0, sb_uf, 0);
    v = vals[vals.size() - 1];

    // Valid with a different value while ready is low: must be ignored.
    check("pulse_ready_low", bus_s.dac_input_ready == 1'b0, int'(bus_s.dac_input_ready), 0);
    drive(1'b1, v ^ 16'h8000);
    @(negedge clk);
    drive(1'b0, 16'h0000);
    i = 0;
    repeat (3 * OSR - 1) begin
      @(negedge clk);
      if (bus_s.dac_underflow) i++;
    end
    check("repeat_underflows", i == 2, i, 2);
    count_ones(OSR, cs, cu);
    check("repeat_last_s", near(cs, ones_per_frame(level_signed(v)), 1), cs, ones_per_frame(level_signed(v)));
    check("repeat_last_u", near(cu, ones_per_frame(level_unsigned(v)), 1), cu, ones_per_frame(level_unsigned(v)));

    // Accept on the strobe cycle while empty.
    w = 16'($urandom_range(0, 65535));
    wait_uf();
    repeat (OSR - 1) @(negedge clk);
    drive(1'b1, w);
    @(negedge clk);
    drive(1'b0, 16'h0000);
    check("strobe_accept_underflow", bus_s.dac_underflow == 1'b1, int'(bus_s.dac_underflow), 1);
    check("strobe_accept_held", bus_s.dac_input_ready == 1'b0, int'(bus_s.dac_input_ready), 0);
    repeat (OSR) @(negedge clk);
    check("next_strobe_consumes", {bus_s.dac_underflow, bus_s.dac_input_ready} == 2'b01,
          int'({bus_s.dac_underflow, bus_s.dac_input_ready}), 1);
    repeat (2 * OSR) @(negedge clk);
    count_ones(OSR, cs, cu);
    check("late_sample_s", near(cs, ones_per_frame(level_signed(w)), 1), cs, ones_per_frame(level_signed(w)));
    check("late_sample_u", near(cu, ones_per_frame(level_unsigned(w)), 1), cu, ones_per_frame(level_unsigned(w)));

    // Reset mid-frame with a sample held.
    wait_uf();
    drive(1'b1, 16'h6000);
    @(negedge clk);
    drive(1'b0, 16'h0000);
    check("hold_full_before_reset", bus_s.dac_input_ready == 1'b0, int'(bus_s.dac_input_ready), 0);
    repeat (10) @(negedge clk);
    apply_reset(1);
    idle_check(512);

    i = 0;
    while ((exp_q.size() != 0 || mon_busy) && i < 4 * OSR) begin
      @(posedge clk);
      i++;
    end
    check("scoreboard_drained", exp_q.size() == 0 && !mon_busy, exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
